// File: rtl/inst_mem_pipe.sv
// Pipelined instruction memory: fetch request/response handshake with RD_LAT read latency,
// an in-order response FIFO sized for the worst-case backlog, and a byte-enabled loader port.
module inst_mem_pipe #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4096,
    parameter int                RD_LAT   = 1,
    parameter logic [DATA_W-1:0] NOP_INST = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_W-1:0]     req_addr_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_W-1:0]     rsp_inst_o,
    output logic [1:0]            rsp_err_o,
    input  logic                  ld_en_i,
    input  logic [ADDR_W-1:0]     ld_addr_i,
    input  logic [DATA_W-1:0]     ld_data_i,
    input  logic [DATA_W/8-1:0]   ld_be_i
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int NB     = DATA_W / 8;
    localparam int FDEPTH = RD_LAT + 1;
    localparam int PTR_W  = $clog2(FDEPTH);
    localparam int CNT_W  = $clog2(FDEPTH + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(FDEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(FDEPTH - 1);
    localparam logic [ADDR_W-3:0] DEPTH_L  = (ADDR_W - 2)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_fd  [FDEPTH];
    logic [1:0]        r_fe  [FDEPTH];
    logic [PTR_W-1:0]  r_wptr, r_rptr;
    logic [CNT_W-1:0]  r_fcnt, r_ocnt;

    logic [ADDR_W-3:0] w_word, w_ld_word;
    logic              w_mis, w_oor, w_accept, w_pop, w_ld_in_range;
    logic [DATA_W-1:0] w_rd_data, w_push_data;
    logic [1:0]        w_rd_err, w_push_err;
    logic              w_push, w_flush_push, w_fifo_wr;
    logic [PTR_W-1:0]  w_wr_idx;
    logic              w_unused_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) ptr_inc = '0;
        else               ptr_inc = p + PTR_W'(1);
    endfunction

    assign w_unused_s    = ^{ld_addr_i[1:0]};
    assign w_word        = req_addr_i[ADDR_W-1:2];
    assign w_mis         = (req_addr_i[1:0] != 2'b00);
    assign w_oor         = (w_word >= DEPTH_L);
    assign w_rd_err      = {w_oor, w_mis};
    // Faulted fetches never touch the array; the read is asynchronous so a same-edge load sees old data
    assign w_rd_data     = (w_mis || w_oor) ? NOP_INST : r_mem[w_word[IDX_W-1:0]];
    assign w_accept      = req_valid_i && req_ready_o;
    assign w_pop         = rsp_valid_o && rsp_ready_i;
    assign req_ready_o   = (r_ocnt < CNT_MAX);
    assign w_ld_word     = ld_addr_i[ADDR_W-1:2];
    assign w_ld_in_range = (w_ld_word < DEPTH_L);

    generate
        if (RD_LAT == 1) begin : g_direct
            assign w_push       = w_accept;
            assign w_push_data  = w_rd_data;
            assign w_push_err   = w_rd_err;
            assign w_flush_push = w_accept;
        end else begin : g_stages
            logic [RD_LAT-2:0] r_pv;
            logic [DATA_W-1:0] r_pd [RD_LAT-1];
            logic [1:0]        r_pe [RD_LAT-1];

            // Delay-line valid bits; a request accepted during flush still enters stage 0
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pv <= '0;
                end else begin
                    r_pv[0] <= w_accept;
                    for (int i = 1; i < RD_LAT - 1; i++) begin
                        r_pv[i] <= flush_i ? 1'b0 : r_pv[i-1];
                    end
                end
            end

            // Delay-line payload, qualified by r_pv so it needs no reset
            always_ff @(posedge clk) begin
                r_pd[0] <= w_rd_data;
                r_pe[0] <= w_rd_err;
                for (int i = 1; i < RD_LAT - 1; i++) begin
                    r_pd[i] <= r_pd[i-1];
                    r_pe[i] <= r_pe[i-1];
                end
            end

            assign w_push       = r_pv[RD_LAT-2];
            assign w_push_data  = r_pd[RD_LAT-2];
            assign w_push_err   = r_pe[RD_LAT-2];
            assign w_flush_push = 1'b0;
        end
    endgenerate

    assign w_fifo_wr = flush_i ? w_flush_push : w_push;
    assign w_wr_idx  = flush_i ? '0 : r_wptr;

    // Loader write port; out-of-range words are dropped
    always_ff @(posedge clk) begin
        if (ld_en_i && w_ld_in_range) begin
            for (int k = 0; k < NB; k++) begin
                if (ld_be_i[k]) r_mem[w_ld_word[IDX_W-1:0]][8*k +: 8] <= ld_data_i[8*k +: 8];
            end
        end
    end

    // Response FIFO payload storage
    always_ff @(posedge clk) begin
        if (w_fifo_wr) begin
            r_fd[w_wr_idx] <= w_push_data;
            r_fe[w_wr_idx] <= w_push_err;
        end
    end

    // Response FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fcnt <= '0;
        end else if (flush_i) begin
            r_rptr <= '0;
            r_wptr <= w_flush_push ? PTR_W'(1) : '0;
            r_fcnt <= w_flush_push ? CNT_W'(1) : '0;
        end else begin
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + CNT_W'(1);
                2'b01:   r_fcnt <= r_fcnt - CNT_W'(1);
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    // Outstanding counter gates acceptance so the FIFO can never overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ocnt <= '0;
        end else if (flush_i) begin
            r_ocnt <= w_accept ? CNT_W'(1) : '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_ocnt <= r_ocnt + CNT_W'(1);
                2'b01:   r_ocnt <= r_ocnt - CNT_W'(1);
                default: r_ocnt <= r_ocnt;
            endcase
        end
    end

    assign rsp_valid_o = (r_fcnt != '0);
    assign rsp_inst_o  = rsp_valid_o ? r_fd[r_rptr] : '0;
    assign rsp_err_o   = rsp_valid_o ? r_fe[r_rptr] : 2'b00;

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Directed bench: instance A uses RD_LAT=1, instance B uses RD_LAT=2; both share the loader port.
module tb_inst_mem_pipe;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int DEP = 64;
    localparam logic [31:0] NOP = 32'h00000013;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          ld_en   = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic [3:0]    ld_be   = 4'h0;

    logic a_flush = 1'b0, a_req_valid = 1'b0, a_rsp_ready = 1'b1;
    logic a_req_ready, a_rsp_valid;
    logic [AW-1:0] a_req_addr = '0;
    logic [DW-1:0] a_rsp_inst;
    logic [1:0]    a_rsp_err;

    logic b_flush = 1'b0, b_req_valid = 1'b0, b_rsp_ready = 1'b0;
    logic b_req_ready, b_rsp_valid;
    logic [AW-1:0] b_req_addr = '0;
    logic [DW-1:0] b_rsp_inst;
    logic [1:0]    b_rsp_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    inst_mem_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(1), .NOP_INST(NOP)) u_a (
        .clk(clk), .rst_n(rst_n), .flush_i(a_flush),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_addr_i(a_req_addr),
        .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready), .rsp_inst_o(a_rsp_inst), .rsp_err_o(a_rsp_err),
        .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .ld_be_i(ld_be));

    inst_mem_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(2), .NOP_INST(NOP)) u_b (
        .clk(clk), .rst_n(rst_n), .flush_i(b_flush),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_addr_i(b_req_addr),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_inst_o(b_rsp_inst), .rsp_err_o(b_rsp_err),
        .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .ld_be_i(ld_be));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        ld_en = 1'b1; ld_addr = addr; ld_data = data; ld_be = be;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (a_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_a_valid: got %b want 0", a_rsp_valid); end
        n_cmp++; if (a_rsp_inst !== 32'h0) begin n_err++; $display("FAIL rst_a_inst: got %h want 00000000", a_rsp_inst); end
        n_cmp++; if (a_rsp_err !== 2'b00) begin n_err++; $display("FAIL rst_a_err: got %b want 00", a_rsp_err); end
        n_cmp++; if (a_req_ready !== 1'b1) begin n_err++; $display("FAIL rst_a_ready: got %b want 1", a_req_ready); end
        n_cmp++; if ({b_rsp_valid, b_rsp_inst, b_rsp_err, b_req_ready} !== {1'b0, 32'h0, 2'b00, 1'b1})
            begin n_err++; $display("FAIL rst_b: got v=%b i=%h e=%b r=%b want v=0 i=0 e=0 r=1", b_rsp_valid, b_rsp_inst, b_rsp_err, b_req_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back;
        load(32'h0, 32'h00500093, 4'hF);
        load(32'h4, 32'h00A00113, 4'hF);
        a_req_valid = 1'b1; a_req_addr = 32'h0;
        n_cmp++; if (a_req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready0: got %b want 1", a_req_ready); end
        tick();
        n_cmp++; if (a_rsp_valid !== 1'b1 || a_rsp_inst !== 32'h00500093 || a_rsp_err !== 2'b00)
            begin n_err++; $display("FAIL b2b_rsp0: got v=%b i=%h e=%b want v=1 i=00500093 e=00", a_rsp_valid, a_rsp_inst, a_rsp_err); end
        n_cmp++; if (a_req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready1: got %b want 1", a_req_ready); end
        a_req_addr = 32'h4;
        tick();
        n_cmp++; if (a_rsp_valid !== 1'b1 || a_rsp_inst !== 32'h00A00113 || a_rsp_err !== 2'b00)
            begin n_err++; $display("FAIL b2b_rsp1: got v=%b i=%h e=%b want v=1 i=00a00113 e=00", a_rsp_valid, a_rsp_inst, a_rsp_err); end
        n_cmp++; if (a_req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready2: got %b want 1", a_req_ready); end
        a_req_valid = 1'b0;
        tick();
        n_cmp++; if (a_rsp_valid !== 1'b0 || a_rsp_inst !== 32'h0)
            begin n_err++; $display("FAIL b2b_idle: got v=%b i=%h want v=0 i=0", a_rsp_valid, a_rsp_inst); end
    endtask

    task automatic test_faults;
        logic [31:0] addrs [3];
        logic [1:0]  errs  [3];
        addrs[0] = 32'h6;           errs[0] = 2'b01;
        addrs[1] = 32'(4 * DEP);     errs[1] = 2'b10;
        addrs[2] = 32'(4 * DEP + 2); errs[2] = 2'b11;
        for (int i = 0; i < 3; i++) begin
            a_req_valid = 1'b1; a_req_addr = addrs[i];
            tick();
            n_cmp++; if (a_rsp_valid !== 1'b1 || a_rsp_inst !== NOP || a_rsp_err !== errs[i])
                begin n_err++; $display("FAIL fault_%0d: got v=%b i=%h e=%b want v=1 i=%h e=%b", i, a_rsp_valid, a_rsp_inst, a_rsp_err, NOP, errs[i]); end
        end
        a_req_valid = 1'b0;
        tick();
    endtask

    task automatic test_byte_enable;
        load(32'h8, 32'h11223344, 4'hF);
        load(32'h8, 32'hAABBCCDD, 4'b0101);
        a_req_valid = 1'b1; a_req_addr = 32'h8;
        tick();
        n_cmp++; if (a_rsp_inst !== 32'h11BB33DD || a_rsp_err !== 2'b00)
            begin n_err++; $display("FAIL byte_en: got i=%h e=%b want i=11bb33dd e=00", a_rsp_inst, a_rsp_err); end
        a_req_valid = 1'b0;
        tick();
    endtask

    task automatic test_collision;
        load(32'hC, 32'h55667788, 4'hF);
        ld_en = 1'b1; ld_addr = 32'hC; ld_data = 32'hDEADBEEF; ld_be = 4'hF;
        a_req_valid = 1'b1; a_req_addr = 32'hC;
        tick();
        ld_en = 1'b0;
        n_cmp++; if (a_rsp_inst !== 32'h55667788)
            begin n_err++; $display("FAIL collide_old: got %h want 55667788", a_rsp_inst); end
        tick();
        n_cmp++; if (a_rsp_inst !== 32'hDEADBEEF)
            begin n_err++; $display("FAIL collide_new: got %h want deadbeef", a_rsp_inst); end
        a_req_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall;
        logic [31:0] addrs [4];
        logic        rdy   [4];
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8; addrs[3] = 32'hC;
        rdy[0] = 1'b1; rdy[1] = 1'b1; rdy[2] = 1'b1; rdy[3] = 1'b0;
        b_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_req_valid = 1'b1; b_req_addr = addrs[i];
            n_cmp++; if (b_req_ready !== rdy[i])
                begin n_err++; $display("FAIL stall_ready_%0d: got %b want %b", i, b_req_ready, rdy[i]); end
            tick();
        end
        b_req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (b_rsp_valid !== 1'b1 || b_rsp_inst !== 32'h00500093 || b_req_ready !== 1'b0)
                begin n_err++; $display("FAIL stall_hold_%0d: got v=%b i=%h r=%b want v=1 i=00500093 r=0", i, b_rsp_valid, b_rsp_inst, b_req_ready); end
            tick();
        end
        b_rsp_ready = 1'b1;
        n_cmp++; if (b_rsp_inst !== 32'h00500093) begin n_err++; $display("FAIL drain_0: got %h want 00500093", b_rsp_inst); end
        tick();
        n_cmp++; if (b_rsp_inst !== 32'h00A00113) begin n_err++; $display("FAIL drain_1: got %h want 00a00113", b_rsp_inst); end
        tick();
        n_cmp++; if (b_rsp_inst !== 32'h11BB33DD) begin n_err++; $display("FAIL drain_2: got %h want 11bb33dd", b_rsp_inst); end
        tick();
        n_cmp++; if (b_rsp_valid !== 1'b0 || b_rsp_inst !== 32'h0 || b_req_ready !== 1'b1)
            begin n_err++; $display("FAIL drain_end: got v=%b i=%h r=%b want v=0 i=0 r=1", b_rsp_valid, b_rsp_inst, b_req_ready); end
    endtask

    task automatic test_flush;
        b_rsp_ready = 1'b1;
        b_req_valid = 1'b1; b_req_addr = 32'h0;
        tick();
        b_req_addr = 32'h8;
        tick();
        b_req_addr = 32'hC;
        tick();
        n_cmp++; if (b_rsp_valid !== 1'b1 || b_rsp_inst !== 32'h11BB33DD)
            begin n_err++; $display("FAIL preflush: got v=%b i=%h want v=1 i=11bb33dd", b_rsp_valid, b_rsp_inst); end
        b_req_addr = 32'h4; b_flush = 1'b1;
        n_cmp++; if (b_req_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b want 1", b_req_ready); end
        tick();
        b_flush = 1'b0; b_req_valid = 1'b0;
        n_cmp++; if (b_rsp_valid !== 1'b0) begin n_err++; $display("FAIL flush_empty: got %b want 0", b_rsp_valid); end
        tick();
        n_cmp++; if (b_rsp_valid !== 1'b1 || b_rsp_inst !== 32'h00A00113 || b_rsp_err !== 2'b00)
            begin n_err++; $display("FAIL flush_new: got v=%b i=%h e=%b want v=1 i=00a00113 e=00", b_rsp_valid, b_rsp_inst, b_rsp_err); end
        tick();
        n_cmp++; if (b_rsp_valid !== 1'b0) begin n_err++; $display("FAIL flush_done: got %b want 0", b_rsp_valid); end
        // An idle counter admits exactly three stalled fetches
        b_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_req_valid = 1'b1; b_req_addr = 32'h0;
            n_cmp++; if (b_req_ready !== (i < 3))
                begin n_err++; $display("FAIL postflush_ready_%0d: got %b want %b", i, b_req_ready, (i < 3)); end
            tick();
        end
        b_req_valid = 1'b0; b_rsp_ready = 1'b1;
        repeat (4) tick();
        n_cmp++; if (b_rsp_valid !== 1'b0 || b_req_ready !== 1'b1)
            begin n_err++; $display("FAIL postflush_drain: got v=%b r=%b want v=0 r=1", b_rsp_valid, b_req_ready); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_faults();
        test_byte_enable();
        test_collision();
        test_stall();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/inst_mem_pipe.md
Name: inst_mem_pipe

Overview:
- Parametrised, pipelined instruction memory. It is the next generation of the core's combinational-read instruction store.
- A fetch request/response handshake with configurable read latency and backpressure replaces the zero-latency array read.
- A byte-enabled loader port fills memory from the testbench or a boot loader.
- Sits between the IF stage (fetch side) and the program loader (load side). It reports misaligned and out-of-range fetches instead of returning garbage.

Parameters:
- DATA_W, 32, instruction/data width in bits (multiple of 8).
- ADDR_W, 32, byte address width.
- DEPTH, 4096, memory depth in words (power of two).
- RD_LAT, 1, array read latency in cycles (legal range 1..3).
- NOP_INST, 32'h00000013, instruction returned on a faulted fetch.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- flush_i  in  1  discard all in-flight and buffered fetches (branch redirect).
- req_valid_i  in  1  fetch request valid.
- req_ready_o  out  1  fetch request can be accepted.
- req_addr_i  in  ADDR_W  fetch byte address (pc).
- rsp_valid_o  out  1  fetch response valid.
- rsp_ready_i  in  1  consumer accepts response.
- rsp_inst_o  out  DATA_W  fetched instruction.
- rsp_err_o  out  2  bit0 misaligned, bit1 out of range.
- ld_en_i  in  1  loader write strobe.
- ld_addr_i  in  ADDR_W  loader byte address (word-aligned; bits[1:0] ignored).
- ld_data_i  in  DATA_W  loader write data.
- ld_be_i  in  DATA_W/8  loader byte enables.

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk (decided).
  - Reset clears: pipeline valid bits, response FIFO, outstanding counter.
  - After reset: rsp_valid_o=0, rsp_inst_o=0, rsp_err_o=0, req_ready_o=1.
  - Memory contents are not reset.
- Word index = req_addr_i[ADDR_W-1:2].
  - Misaligned: req_addr_i[1:0]!=0.
  - Out of range: word index >= DEPTH.
  - Either fault → response carries NOP_INST with the corresponding err bits set. Both bits may be set together. The array is not read.
- Request accept: req_valid_i & req_ready_o at a rising edge. The accepted request enters a RD_LAT-stage pipeline.
- Response timing: an accepted request becomes available exactly RD_LAT cycles later when the FIFO is empty and the consumer is ready. Otherwise it waits in the response FIFO.
- Response FIFO: depth RD_LAT+1.
  - rsp_valid_o = FIFO not empty. Head drives rsp_inst_o/rsp_err_o.
  - Outputs are held stable while rsp_valid_o & !rsp_ready_i.
  - rsp_inst_o and rsp_err_o are 0 whenever rsp_valid_o=0.
  - Responses are strictly in request order.
- Outstanding counter (requests accepted but not yet consumed, range 0..RD_LAT+1):
  - +1 on accept, -1 on rsp handshake; both in the same cycle → unchanged.
  - req_ready_o = (count < RD_LAT+1). It depends on the counter only, never combinationally on rsp_ready_i.
  - With rsp_ready_i held high this sustains 1 fetch/cycle.
  - The FIFO can never overflow.
- Flush: flush_i high at an edge:
  - All pipeline entries and FIFO entries are discarded and count becomes 0.
  - rsp_valid_o=0 the following cycle.
  - A request accepted in the same cycle as flush_i is kept as the first post-flush fetch; count=1.
  - A response handshaking in the flush cycle is considered consumed.
- Loader write (ld_en_i at edge): bytes with ld_be_i[k]=1 are written at word ld_addr_i[ADDR_W-1:2]. Out-of-range loader writes are silently dropped.
- Collision: a loader write and a fetch array read of the same word in the same cycle → the fetch returns the old data (read-before-write). The new data is visible to requests accepted on the next cycle or later.
- Reset mid-operation: all in-flight fetches are lost and no response is produced for them. Memory contents are retained.

Test Plan:
- Load word 0 = 0x00500093, word 1 = 0x00A00113 (be=4'hF). RD_LAT=1, rsp_ready_i=1, fetch 0x0,0x4 back-to-back → rsp_inst_o 0x00500093 then 0x00A00113 on consecutive cycles, err=0, req_ready_o constantly 1.
- Fetch 0x6 → NOP 0x00000013, err=2'b01. Fetch 4*DEPTH → NOP, err=2'b10. Fetch 4*DEPTH+2 → NOP, err=2'b11.
- RD_LAT=2, rsp_ready_i=0, issue 4 fetches → exactly 3 accepted, then req_ready_o=0. rsp_inst_o stable while stalled. Raise rsp_ready_i → 3 responses in order, then req_ready_o=1.
- Word 2 = 0x11223344, write 0xAABBCCDD with be=4'b0101 → a subsequent fetch 0x8 returns 0x11BB33DD.
- Same-cycle loader write of 0xDEADBEEF to word 3 and fetch of 0xC → old value returned. Re-fetch → 0xDEADBEEF.
- Three fetches in flight, assert flush_i with a new fetch to 0x4 in the same cycle → only the 0x4 response appears. Count returns to 0 after it is consumed.
